// File: rtl/display_scene_ctrl_pkg.sv
// display_scene_ctrl_pkg: scene encoding, RGB565 colours and scene helpers for the display path
package display_scene_ctrl_pkg;
    typedef enum logic [1:0] {
        SCENE_TITLE = 2'd0,
        SCENE_PLAY  = 2'd1,
        SCENE_WIN   = 2'd2,
        SCENE_LOSE  = 2'd3
    } scene_t;
    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] RED   = 16'hF800;
    function automatic logic is_end(scene_t s);
        return s == SCENE_WIN || s == SCENE_LOSE;
    endfunction
endpackage

// File: rtl/display_scene_ctrl_if.sv
// display_scene_ctrl_if: pixel position, game events, per-scene pixels and scene status
interface display_scene_ctrl_if;
    import display_scene_ctrl_pkg::*;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        start_req;
    logic        win_evt;
    logic        lose_evt;
    logic [15:0] play_pix;
    logic [15:0] win_pix;
    logic [15:0] lose_pix;
    logic [15:0] pix_data;
    scene_t      scene;
    logic        game_run;
    logic        restart_ok;
    modport master (
        output pix_x, pix_y, start_req, win_evt, lose_evt, play_pix, win_pix, lose_pix,
        input  pix_data, scene, game_run, restart_ok
    );
    modport slave (
        input  pix_x, pix_y, start_req, win_evt, lose_evt, play_pix, win_pix, lose_pix,
        output pix_data, scene, game_run, restart_ok
    );
endinterface

// File: rtl/display_scene_ctrl_frame_tick.sv
// display_scene_ctrl_frame_tick: (0,0) entry detector plus an 8-bit frame counter saturating at lim_i
module display_scene_ctrl_frame_tick (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pix_x_i,
    input  logic [9:0] pix_y_i,
    input  logic       clr_i,
    input  logic [7:0] lim_i,
    output logic       fs_o,
    output logic       sat_o
);
    logic       at00;
    logic       was_q;
    logic [7:0] cnt_q, cnt_d;
    // frame start on entry to (0,0); clear wins over counting
    always_comb begin
        at00  = pix_x_i == 10'd0 && pix_y_i == 10'd0;
        fs_o  = at00 && !was_q;
        sat_o = cnt_q == lim_i;
        cnt_d = clr_i ? 8'd0 : (fs_o && !sat_o) ? cnt_q + 8'd1 : cnt_q;
    end
    // was-(0,0) flag resets high so releasing reset at (0,0) is not a frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            was_q <= 1'b1;
            cnt_q <= 8'd0;
        end else begin
            was_q <= at00;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/display_scene_ctrl.sv
// display_scene_ctrl: frame-synchronous scene sequencer and per-scene pixel mux
module display_scene_ctrl
    import display_scene_ctrl_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                 vga_clk,
    input  logic                 sys_rst,
    display_scene_ctrl_if.slave  bus
);
    scene_t      st_q, st_d;
    logic [2:0]  pend_q, pend_d, pend;
    logic        blink_q, blink_d, game_run_q;
    logic        fs, fs_b, sat_h, sat_b, clr_h, clr_b, wrap;
    logic [15:0] pix_q, pix_d;

    display_scene_ctrl_frame_tick u_hold (
        .clk(vga_clk), .rst(sys_rst), .pix_x_i(bus.pix_x), .pix_y_i(bus.pix_y),
        .clr_i(clr_h), .lim_i(8'(HOLD_FRAMES)), .fs_o(fs), .sat_o(sat_h)
    );

    display_scene_ctrl_frame_tick u_blink (
        .clk(vga_clk), .rst(sys_rst), .pix_x_i(bus.pix_x), .pix_y_i(bus.pix_y),
        .clr_i(clr_b), .lim_i(8'(BLINK_FRAMES - 1)), .fs_o(fs_b), .sat_o(sat_b)
    );

    // pend = {start, win, lose}; events in the frame-start cycle itself count, then everything clears
    always_comb begin
        pend    = pend_q | {bus.start_req, bus.win_evt, bus.lose_evt};
        pend_d  = fs ? 3'b000 : pend;
        st_d    = !fs                  ? st_q :
                  st_q == SCENE_TITLE  ? (pend[2] ? SCENE_PLAY : SCENE_TITLE) :
                  st_q == SCENE_PLAY   ? (pend[0] ? SCENE_LOSE : pend[1] ? SCENE_WIN : SCENE_PLAY) :
                  (pend[2] && sat_h)   ? SCENE_PLAY : st_q;
        clr_h   = !is_end(st_q) || st_d != st_q;
        wrap    = fs_b && sat_b;
        clr_b   = st_q != SCENE_TITLE || wrap;
        blink_d = st_q == SCENE_TITLE && (blink_q ^ wrap);
        pix_d   = (bus.pix_x >= 10'(H_ACTIVE) || bus.pix_y >= 10'(V_ACTIVE)) ? BLACK :
                  st_d == SCENE_TITLE ? (blink_d ? bus.play_pix : BLACK) :
                  st_d == SCENE_PLAY  ? bus.play_pix :
                  st_d == SCENE_WIN   ? bus.win_pix : bus.lose_pix;
    end

    // scene, pending events, blink phase and pixel register
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            st_q       <= SCENE_TITLE;
            pend_q     <= 3'b000;
            blink_q    <= 1'b0;
            game_run_q <= 1'b0;
            pix_q      <= BLACK;
        end else begin
            st_q       <= st_d;
            pend_q     <= pend_d;
            blink_q    <= blink_d;
            game_run_q <= st_d == SCENE_PLAY;
            pix_q      <= pix_d;
        end
    end

    assign bus.scene      = st_q;
    assign bus.game_run   = game_run_q;
    assign bus.restart_ok = is_end(st_q) && sat_h;
    assign bus.pix_data   = pix_q;
endmodule
